// File: rtl/core_config_pkg.sv
`default_nettype none
// ============================================================================
// core_config_pkg -- core-wide widths and CSR execution types
// Revision: 1.0
// ============================================================================
package core_config_pkg;

  localparam int CFG_XLEN       = 32;
  localparam int CFG_CSR_ADDR_W = 12;
  localparam int CFG_TAG_W      = 6;

  // Address bits [11:10] == 2'b11 mark a read-only CSR
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  // Encoding follows the funct3 field of the Zicsr instructions
  typedef enum logic [2:0] {
    CSR_RW  = 3'd1,
    CSR_RS  = 3'd2,
    CSR_RC  = 3'd3,
    CSR_RWI = 3'd5,
    CSR_RSI = 3'd6,
    CSR_RCI = 3'd7
  } csr_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_MODIFY = 2'd2,
    ST_RESP   = 2'd3
  } csr_state_t;

  function automatic logic op_always_writes(input csr_op_t op);
    return (op == CSR_RW) || (op == CSR_RWI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_exec_if.sv
`default_nettype none
// ============================================================================
// csr_exec_if -- issue, writeback and CSR-file port bundle of csr_exec_unit
// Revision: 1.0
// ============================================================================
interface csr_exec_if
  import core_config_pkg::*;
#(
  parameter int XLEN       = CFG_XLEN,
  parameter int CSR_ADDR_W = CFG_CSR_ADDR_W,
  parameter int TAG_W      = CFG_TAG_W
) ();

  logic                  in_valid;
  logic                  in_ready;
  csr_op_t               in_op;
  logic [CSR_ADDR_W-1:0] in_addr;
  logic [XLEN-1:0]       in_src;
  logic                  in_src_zero;
  logic [TAG_W-1:0]      in_tag;

  logic [CSR_ADDR_W-1:0] csr_ra;
  logic [XLEN-1:0]       csr_rd;
  logic                  csr_err;
  logic [CSR_ADDR_W-1:0] csr_wa;
  logic [XLEN-1:0]       csr_wd;
  logic                  csr_we;

  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_data;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_exc;

  modport master (
    output in_valid, in_op, in_addr, in_src, in_src_zero, in_tag,
    input  in_ready,
    input  csr_ra, csr_wa, csr_wd, csr_we,
    output csr_rd, csr_err,
    input  out_valid, out_data, out_tag, out_exc,
    output out_ready
  );

  modport slave (
    input  in_valid, in_op, in_addr, in_src, in_src_zero, in_tag,
    output in_ready,
    output csr_ra, csr_wa, csr_wd, csr_we,
    input  csr_rd, csr_err,
    output out_valid, out_data, out_tag, out_exc,
    input  out_ready
  );

endinterface
`default_nettype wire

// File: rtl/csr_modify_alu.sv
`default_nettype none
// ============================================================================
// csr_modify_alu -- new CSR value from old value, source operand and op
// Revision: 1.0
// ============================================================================
module csr_modify_alu
  import core_config_pkg::*;
#(
  parameter int XLEN = CFG_XLEN
) (
  input  csr_op_t         op,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] src,
  output logic [XLEN-1:0] new_val
);

  always_comb begin
    new_val = old;
    case (op)
      CSR_RW, CSR_RWI: new_val = src;
      CSR_RS, CSR_RSI: new_val = old | src;
      CSR_RC, CSR_RCI: new_val = old & ~src;
      default:         new_val = old;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/csr_exec_unit.sv
`default_nettype none
// ============================================================================
// csr_exec_unit -- Zicsr read-modify-write stage, one op in flight
// Revision: 1.0
// ============================================================================
module csr_exec_unit
  import core_config_pkg::*;
#(
  parameter int XLEN       = CFG_XLEN,
  parameter int CSR_ADDR_W = CFG_CSR_ADDR_W,
  parameter int TAG_W      = CFG_TAG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         flush,
  csr_exec_if.slave    bus
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_READ   = ST_READ;
  localparam logic [1:0] S_MODIFY = ST_MODIFY;
  localparam logic [1:0] S_RESP   = ST_RESP;

  logic [1:0]            r_state;
  csr_op_t               r_op;
  logic [CSR_ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]       r_src;
  logic                  r_src_zero;
  logic [TAG_W-1:0]      r_tag;
  logic [XLEN-1:0]       r_old;
  logic                  r_exc;

  logic                  w_in_read;
  logic                  w_in_modify;
  logic                  w_in_resp;
  logic                  w_do_write;
  logic                  w_ro_viol;
  logic [XLEN-1:0]       w_new;

  assign w_in_read   = (r_state == S_READ);
  assign w_in_modify = (r_state == S_MODIFY);
  assign w_in_resp   = (r_state == S_RESP);

  assign w_do_write = op_always_writes(r_op) || !r_src_zero;
  assign w_ro_viol  = w_do_write && (r_addr[CSR_ADDR_W-1 -: 2] == CSR_RO_PREFIX);

  csr_modify_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .op      (r_op),
    .old     (bus.csr_rd),
    .src     (r_src),
    .new_val (w_new)
  );

  // Read address is held through MODIFY so a clk_en stall re-reads the same CSR
  assign bus.csr_ra = (w_in_read || w_in_modify) ? r_addr : '0;
  assign bus.csr_wa = w_in_modify ? r_addr : '0;
  assign bus.csr_wd = w_in_modify ? w_new : '0;
  assign bus.csr_we = w_in_modify && w_do_write && !bus.csr_err && !w_ro_viol
                      && !flush && clk_en;

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = w_in_resp;
  assign bus.out_data  = (w_in_resp && !r_exc) ? r_old : '0;
  assign bus.out_tag   = w_in_resp ? r_tag : '0;
  assign bus.out_exc   = w_in_resp && r_exc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= CSR_RW;
      r_addr     <= '0;
      r_src      <= '0;
      r_src_zero <= 1'b0;
      r_tag      <= '0;
      r_old      <= '0;
      r_exc      <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.in_valid) begin
              r_op       <= bus.in_op;
              r_addr     <= bus.in_addr;
              r_src      <= bus.in_src;
              r_src_zero <= bus.in_src_zero;
              r_tag      <= bus.in_tag;
              r_state    <= S_READ;
            end
          end
          S_READ: begin
            r_state <= S_MODIFY;
          end
          S_MODIFY: begin
            r_old   <= bus.csr_rd;
            r_exc   <= bus.csr_err || w_ro_viol;
            r_state <= S_RESP;
          end
          S_RESP: begin
            if (bus.out_ready) r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_exec_unit.sv
`default_nettype none
// ============================================================================
// tb_csr_exec_unit -- directed bench with a transaction-level CSR model
// Revision: 1.0
// ============================================================================
module tb_csr_exec_unit;
  import core_config_pkg::*;

  typedef struct {
    bit          we;
    logic [31:0] wd;
    logic [31:0] data;
    bit          exc;
  } exp_t;

  logic clk;
  logic rst;
  logic clk_en;
  logic flush;

  csr_exec_if bus ();

  csr_exec_unit dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .flush  (flush),
    .bus    (bus)
  );

  logic [31:0] csr_mem [0:4095];
  bit          err_map [0:4095];

  int          total = 0;
  int          bad   = 0;
  bit          chk_on = 0;
  bit          cur_live = 0;
  bit          wrote = 0;
  exp_t        cur_exp;
  logic [11:0] cur_addr;
  logic [5:0]  cur_tag;
  logic [31:0] last_wd, last_data;
  logic        last_exc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Spec-level result of one op given the CSR file contents at issue time
  function automatic exp_t model(input csr_op_t op, input logic [11:0] addr,
                                 input logic [31:0] src, input bit sz,
                                 input logic [31:0] old, input bit err);
    exp_t m;
    bit   writes, ro;
    writes = (op == CSR_RW || op == CSR_RWI) || !sz;
    ro     = writes && (addr >= 12'hC00);
    m.exc  = err || ro;
    m.data = m.exc ? 32'h0 : old;
    m.we   = writes && !m.exc;
    if (op == CSR_RW || op == CSR_RWI)      m.wd = src;
    else if (op == CSR_RS || op == CSR_RSI) m.wd = old | src;
    else                                    m.wd = old & ~src;
    return m;
  endfunction

  // CSR file: registered read, write on the strobe
  initial begin
    bus.csr_rd  = '0;
    bus.csr_err = 1'b0;
    forever begin
      @(posedge clk);
      bus.csr_rd  <= csr_mem[bus.csr_ra];
      bus.csr_err <= err_map[bus.csr_ra];
      if (bus.csr_we === 1'b1) csr_mem[bus.csr_wa] = bus.csr_wd;
    end
  end

  // Per-cycle compare against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        if (bus.out_valid) begin
          chk("resp_live", 32'(cur_live), 32'd1);
          chk("out_data", bus.out_data, cur_exp.data);
          chk("out_exc", 32'(bus.out_exc), 32'(cur_exp.exc));
          chk("out_tag", 32'(bus.out_tag), 32'(cur_tag));
          chk("ready_in_resp", 32'(bus.in_ready), 32'd0);
        end else begin
          chk("idle_data", bus.out_data, 32'd0);
          chk("idle_flags", {25'd0, bus.out_exc, bus.out_tag}, 32'd0);
        end
        if (bus.csr_we) begin
          chk("we_expected", 32'(cur_live && cur_exp.we && !wrote), 32'd1);
          chk("csr_wa", 32'(bus.csr_wa), 32'(cur_addr));
          chk("csr_wd", bus.csr_wd, cur_exp.wd);
          wrote   = 1'b1;
          last_wd = bus.csr_wd;
        end
      end
    end
  end

  task automatic check_reset_outs();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_out_exc", 32'(bus.out_exc), 32'd0);
    chk("rst_csr_we", 32'(bus.csr_we), 32'd0);
    chk("rst_csr_ra", 32'(bus.csr_ra), 32'd0);
    chk("rst_csr_wa", 32'(bus.csr_wa), 32'd0);
    chk("rst_csr_wd", bus.csr_wd, 32'd0);
  endtask

  task automatic drive_op(input csr_op_t op, input logic [11:0] addr,
                          input logic [31:0] src, input bit sz, input logic [5:0] tag);
    bus.in_valid    = 1'b1;
    bus.in_op       = op;
    bus.in_addr     = addr;
    bus.in_src      = src;
    bus.in_src_zero = sz;
    bus.in_tag      = tag;
    cur_exp  = model(op, addr, src, sz, csr_mem[addr], err_map[addr]);
    cur_addr = addr;
    cur_tag  = tag;
    wrote    = 1'b0;
    cur_live = 1'b1;
  endtask

  task automatic clear_in();
    bus.in_valid    = 1'b0;
    bus.in_src      = '0;
    bus.in_src_zero = 1'b0;
  endtask

  task automatic run_op(input csr_op_t op, input logic [11:0] addr, input logic [31:0] src,
                        input bit sz, input logic [5:0] tag, input int ready_hold,
                        input int en_stall, input bit b2b);
    int lat;
    bit seen;
    if (!b2b) begin
      @(posedge clk); #2;
    end
    drive_op(op, addr, src, sz, tag);
    bus.out_ready = (ready_hold == 0);
    @(negedge clk);
    chk("accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #2;
    clear_in();
    if (en_stall > 0) begin
      clk_en = 1'b0;
      repeat (en_stall) @(posedge clk);
      #2;
      clk_en = 1'b1;
    end
    lat  = en_stall;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("resp_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(3 + en_stall));
    last_data = bus.out_data;
    last_exc  = bus.out_exc;
    for (int k = 0; k < ready_hold; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", bus.out_data, last_data);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    if (ready_hold > 0) begin
      @(posedge clk); #2;
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #2;
    cur_live = 1'b0;
    chk("write_done", 32'(wrote), 32'(cur_exp.we));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = 32'(i) * 32'd3;
      err_map[i] = 1'b0;
    end
    csr_mem[12'h340] = 32'h12345678;
    csr_mem[12'h300] = 32'h000000F0;
    csr_mem[12'hC00] = 32'd42;
    err_map[12'h7FF] = 1'b1;

    rst = 1'b1; clk_en = 1'b1; flush = 1'b0;
    bus.in_op = CSR_RW; bus.in_addr = '0; bus.in_tag = '0;
    clear_in();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outs();
    @(posedge clk); #2;
    rst = 1'b0;
    chk_on = 1'b1;

    // CSRRW: old value returned, new value written
    run_op(CSR_RW, 12'h340, 32'hDEADBEEF, 1'b0, 6'd5, 0, 0, 1'b0);
    chk("lit_rw_wd", last_wd, 32'hDEADBEEF);
    chk("lit_rw_data", last_data, 32'h12345678);
    chk("lit_rw_mem", csr_mem[12'h340], 32'hDEADBEEF);

    run_op(CSR_RS, 12'h300, 32'h0000000F, 1'b0, 6'd1, 0, 0, 1'b0);
    chk("lit_rs_wd", last_wd, 32'h000000FF);
    run_op(CSR_RC, 12'h300, 32'h000000F0, 1'b0, 6'd2, 0, 0, 1'b0);
    chk("lit_rc_wd", last_wd, 32'h0000000F);
    run_op(CSR_RSI, 12'h300, 32'h0, 1'b1, 6'd3, 0, 0, 1'b0);
    chk("lit_rsi0_data", last_data, 32'h0000000F);

    // Read-only CSR
    run_op(CSR_RW, 12'hC00, 32'h1, 1'b0, 6'd4, 0, 0, 1'b0);
    chk("lit_ro_exc", 32'(last_exc), 32'd1);
    chk("lit_ro_data", last_data, 32'd0);
    run_op(CSR_RS, 12'hC00, 32'h0, 1'b1, 6'd6, 0, 0, 1'b0);
    chk("lit_ro_read", last_data, 32'd42);
    chk("lit_ro_read_exc", 32'(last_exc), 32'd0);

    // Unimplemented CSR with writeback stall
    run_op(CSR_RW, 12'h7FF, 32'h5, 1'b0, 6'd7, 5, 0, 1'b0);
    chk("lit_err_exc", 32'(last_exc), 32'd1);
    chk("lit_err_data", last_data, 32'd0);

    // flush in MODIFY
    @(posedge clk); #2;
    drive_op(CSR_RW, 12'h340, 32'hAAAA5555, 1'b0, 6'd8);
    @(posedge clk); #2;
    clear_in();
    @(posedge clk); #2;
    flush = 1'b1;
    cur_live = 1'b0;
    @(negedge clk);
    chk("flush_we", 32'(bus.csr_we), 32'd0);
    @(posedge clk); #2;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_no_valid", 32'(bus.out_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("lit_flush_mem", csr_mem[12'h340], 32'hDEADBEEF);

    // rst in READ
    @(posedge clk); #2;
    drive_op(CSR_RW, 12'h341, 32'h11111111, 1'b0, 6'd9);
    @(posedge clk); #2;
    clear_in();
    rst = 1'b1;
    cur_live = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outs();
    repeat (3) @(negedge clk);
    chk("lit_rst_mem", csr_mem[12'h341], 32'h341 * 32'd3);

    // clk_en low for 3 cycles during READ
    run_op(CSR_RCI, 12'h300, 32'h3, 1'b0, 6'd10, 0, 3, 1'b0);
    chk("lit_stall_wd", last_wd, 32'h0000000C);
    chk("lit_stall_data", last_data, 32'h0000000F);

    // back-to-back: second op presented right after the first handshake
    run_op(CSR_RWI, 12'h341, 32'h1F, 1'b0, 6'd11, 0, 0, 1'b0);
    run_op(CSR_RS, 12'h341, 32'h100, 1'b0, 6'd12, 0, 0, 1'b1);
    chk("lit_b2b_data", last_data, 32'h0000001F);
    chk("lit_b2b_wd", last_wd, 32'h0000011F);

    // flush with in_valid in IDLE: op must not be accepted
    @(posedge clk); #2;
    bus.in_valid = 1'b1; bus.in_op = CSR_RW; bus.in_addr = 12'h340;
    bus.in_src = 32'h1; bus.in_src_zero = 1'b0; bus.in_tag = 6'd13;
    flush = 1'b1;
    @(posedge clk); #2;
    clear_in();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_ra", 32'(bus.csr_ra), 32'd0);
    chk("flush_idle_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("lit_flush_idle_mem", csr_mem[12'h340], 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
